// File: rtl/dp_ram_pkg.sv
// Shared definitions for the dual-port RAM and its clients.
//   DEFAULT_DATA_WIDTH / DEFAULT_DEPTH : default geometry
//   cnt_op_e                           : occupancy update selector
//   ptr_next()                         : wrap-around pointer increment for any depth
package dp_ram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 1000;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Explicit wrap at depth-1 so non-power-of-two depths never rely on
  // natural binary overflow.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/dp_ram_async_read.sv
// True dual-port RAM with synchronous writes and asynchronous (combinational) reads.
//   clk            : write clock
//   we_a/addr_a    : port A write enable / address
//   din_a/dout_a   : port A write data / read data
//   we_b/addr_b    : port B write enable / address
//   din_b/dout_b   : port B write data / read data
// If both ports write the same address in one cycle, port B wins.
module dp_ram_async_read
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= din_a;
    end
    if (we_b) begin
      mem[addr_b] <= din_b;
    end
  end

  assign dout_a = mem[addr_a];
  assign dout_b = mem[addr_b];

endmodule

// File: rtl/dp_ram_fifo.sv
// Single-clock show-ahead FIFO built on dp_ram_async_read.
// Port A of the RAM is the write side, port B the read side.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : synchronous clear of pointers/occupancy (RAM untouched)
//   wr_valid/wr_ready : producer handshake, wr_data is the pushed word
//   rd_valid/rd_ready : consumer handshake, rd_data is the head word
//   count/full/empty  : registered occupancy status
module dp_ram_fifo
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic    push;
  logic    pop;
  cnt_op_e cnt_op;

  logic [DATA_WIDTH-1:0] dout_a_unused;

  // Status comes straight from the occupancy register, so it only moves on edges.
  assign full  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Handshake outputs depend only on registered state and rst/flush, never on
  // wr_valid or rd_ready, so no combinational loop can form through a peer.
  assign wr_ready = !full  && !rst && !flush;
  assign rd_valid = !empty && !rst && !flush;

  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_op   = CNT_HOLD;

    if (push) begin
      wr_ptr_d = ADDR_WIDTH'(ptr_next(32'(wr_ptr_q), DEPTH));
    end
    if (pop) begin
      rd_ptr_d = ADDR_WIDTH'(ptr_next(32'(rd_ptr_q), DEPTH));
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    if (push && !pop) begin
      cnt_op = CNT_INC;
    end else if (pop && !push) begin
      cnt_op = CNT_DEC;
    end

    case (cnt_op)
      CNT_INC: count_d = count_q + CNT_WIDTH'(1);
      CNT_DEC: count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // rst and flush have the same effect; memory contents are left stale and
  // become unreachable once the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  dp_ram_async_read #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_a   (push),
    .addr_a (wr_ptr_q),
    .din_a  (wr_data),
    .dout_a (dout_a_unused),
    .we_b   (1'b0),
    .addr_b (rd_ptr_q),
    .din_b  ({DATA_WIDTH{1'b0}}),
    .dout_b (rd_data)
  );

endmodule

// File: tb/tb_dp_ram_fifo.sv
module tb_dp_ram_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             wr_valid;
  logic             wr_ready;
  logic [DW-1:0]    wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [DW-1:0]    rd_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  int total = 0;
  int bad   = 0;

  // Scoreboard: words expected at the head, in order.
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  dp_ram_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // One clock cycle: drive at the falling edge, check status and any pop
  // against the scoreboard, update the scoreboard, then let the edge happen.
  task automatic step(input logic wv, input logic [DW-1:0] wd,
                      input logic rr, input logic fl);
    logic          exp_wr_ready;
    logic          exp_rd_valid;
    logic [DW-1:0] exp_data;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    #1;
    exp_wr_ready = !fl && (sb.size() < DEPTH);
    exp_rd_valid = !fl && (sb.size() > 0);
    total++;
    if (wr_ready !== exp_wr_ready) begin
      bad++;
      $display("FAIL wr_ready: got %b expected %b", wr_ready, exp_wr_ready);
    end
    total++;
    if (rd_valid !== exp_rd_valid) begin
      bad++;
      $display("FAIL rd_valid: got %b expected %b", rd_valid, exp_rd_valid);
    end
    total++;
    if (count !== CNT_W'(sb.size())) begin
      bad++;
      $display("FAIL count: got %0d expected %0d", count, sb.size());
    end
    total++;
    if (full !== (sb.size() == DEPTH)) begin
      bad++;
      $display("FAIL full: got %b expected %b", full, sb.size() == DEPTH);
    end
    total++;
    if (empty !== (sb.size() == 0)) begin
      bad++;
      $display("FAIL empty: got %b expected %b", empty, sb.size() == 0);
    end
    if (exp_rd_valid && rr) begin
      exp_data = sb.pop_front();
      total++;
      if (rd_data !== exp_data) begin
        bad++;
        $display("FAIL pop_data: got %02h expected %02h", rd_data, exp_data);
      end else begin
        $display("pop  %02h", rd_data);
      end
    end
    if (exp_wr_ready && wv) begin
      sb.push_back(wd);
      $display("push %02h", wd);
    end
    if (fl) begin
      sb.delete();
      $display("flush");
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL reset_status: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full);
    end
    total++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: got rd_valid=%b wr_ready=%b expected 0/0", rd_valid, wr_ready);
    end
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    total++;
    if (wr_ready !== 1'b1 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: got wr_ready=%b rd_valid=%b expected 1/0", wr_ready, rd_valid);
    end
    $display("reset released");
  endtask

  task automatic test_basic_order();
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    step(1'b0, 8'h00, 1'b0, 1'b1);        // realign pointers to 0
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 8'h06, 1'b0, 1'b0);        // refused: FIFO full
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 7; i <= 9; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    #1;
    total++;
    if (dut.wr_ptr_q !== AW'(3)) begin
      bad++;
      $display("FAIL wr_ptr_wrap: got %0d expected 3", dut.wr_ptr_q);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_push_pop();
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, DW'(8'h20 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'h50, 1'b1, 1'b0);        // full: only the pop is taken
    step(1'b1, 8'h51, 1'b0, 1'b0);        // slot freed, push accepted
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_empty_boundary();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    #1;
    total++;
    if (count !== '0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL flush_clear: got count=%0d empty=%b expected 0/1", count, empty);
    end
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_wrap();
    test_push_pop();
    test_empty_boundary();
    test_flush();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_ram_fifo.md
# dp_ram_fifo

Single-clock show-ahead FIFO that drives the write and read ports of `dp_ram_async_read`: port A is the write initiator, port B the read initiator. It converts the RAM's raw address/enable interface into valid/ready streams on both sides, with wrap-around pointers for any `DEPTH`, not only powers of two. It sits between a producer stream and a consumer stream wherever the design buffers data in the DP RAM.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width; passed to the RAM.
- `DEPTH`, 1000, entries; passed to the RAM as `MEM_DEPTH`; must be ≥ 2.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, pointer width; derived, not overridden.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear of FIFO state; memory contents untouched.
- `wr_valid` in 1: producer has a word.
- `wr_ready` out 1: FIFO accepts a word.
- `wr_data` in `DATA_WIDTH`: write word.
- `rd_valid` out 1: `rd_data` holds the head word.
- `rd_ready` in 1: consumer takes the head word.
- `rd_data` out `DATA_WIDTH`: head word, combinational from RAM `dout_b`.
- `count` out `$clog2(DEPTH+1)`: current occupancy.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.

## Operation
- State: `wr_ptr`, `rd_ptr` (`ADDR_WIDTH`), `count`, all registered. No explicit FSM. Occupancy is `count`-based, so there is no pointer-equality ambiguity.
- Push = `wr_valid && wr_ready`. Pop = `rd_valid && rd_ready`.
- `wr_ready = !full && !rst && !flush`.
- `rd_valid = !empty && !rst && !flush`.
- RAM port A: `we_a = push`, `addr_a = wr_ptr`, `din_a = wr_data`. `dout_a` is unused.
- RAM port B: `we_b = 0`, `din_b = 0`, `addr_b = rd_ptr`, `rd_data = dout_b`.
- Pointer advance: `next = (ptr == DEPTH-1) ? 0 : ptr + 1`. Wrap is explicit, never a natural overflow.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, both pointers advance.
- Full: `wr_ready = 0` and `wr_data` is ignored. There is no write-through on pop while full. A simultaneous pop still completes and frees the slot for the next cycle.
- Empty: `rd_valid = 0` and there is no bypass. `rd_data` is don't-care.
- `flush` or `rst`: next edge sets `wr_ptr = rd_ptr = count = 0`. Any push or pop in that cycle is discarded. `rst` has priority; `flush` behaves identically.
- Reset values: `count = 0`, `empty = 1`, `full = 0`. `wr_ready` and `rd_valid` are 0 while `rst` is high; from the first cycle after, `wr_ready = 1` and `rd_valid = 0`.
- Reset mid-stream: all buffered words are dropped. RAM contents are stale but unreachable.

## Timing
- Write-to-read latency: 1 cycle. A word pushed at edge N is presented with `rd_valid = 1` after edge N (empty FIFO).
- Read latency: 0 cycles. `rd_data` follows `rd_ptr` combinationally through the async-read RAM.
- `full`, `empty` and `count` change only on clock edges.
- `wr_ready` and `rd_valid` depend combinationally only on registered state plus `rst`/`flush`. There are no combinational paths from `wr_valid` or `rd_ready`.
- Throughput: one push and one pop per cycle, sustained.

## Structure
- Shared package `dp_ram_pkg`:
  - `DEFAULT_DATA_WIDTH = 8`, `DEFAULT_DEPTH = 1000`.
  - function `ptr_next(ptr, depth)` implementing the wrap rule, reused by future RAM clients.
- One sub-module: instance `u_ram` of `dp_ram_async_read` (`DATA_WIDTH`, `MEM_DEPTH = DEPTH`).
- Control logic lives in this block. Expected size is about 150 lines.

## Test plan
- Reset/idle: hold `rst` for 2 cycles → `count = 0`, `empty = 1`, `full = 0`, `rd_valid = 0`. One cycle after release, `wr_ready = 1`.
- Basic order: push 0xAA, 0xBB, 0xCC on consecutive cycles, then pop 3 → `rd_data` sequence AA, BB, CC. `count` goes 1, 2, 3 then 2, 1, 0; `empty = 1` at the end.
- Wrap, non-power-of-two (bench overrides `DEPTH = 5`):
  - push 0x01..0x05 → `full = 1`, `wr_ready = 0`.
  - a 6th push of 0x06 is ignored.
  - pop 3 → 01, 02, 03.
  - push 0x07, 0x08, 0x09 → `wr_ptr` wrapped to 3.
  - drain → 04, 05, 07, 08, 09.
- Simultaneous push/pop (`DEPTH = 5`):
  - at `count = 2`, 10 cycles of push+pop → `count` stays 2 and data order is preserved.
  - at `count = 5`, push+pop → only the pop is taken, `count = 4`; next cycle `wr_ready = 1`.
- Empty-side boundary: `rd_ready = 1` held while empty → no pop and `count` stays 0. Push 0x5A → `rd_valid = 1` one edge later with `rd_data = 0x5A`.
- Flush/reset mid-operation: with `count = 3`, pulse `flush` while `wr_valid = 1` and `rd_ready = 1` → `count = 0`, `empty = 1`, that push is dropped. Push 0x77 → next pop returns 0x77.
